// File: rtl/tea_arbiter.sv
// Round-robin arbiter that shares one iterative TEA core between two AXI-Stream requester channels.
// Optional: define TEA_ARB_STATS_EN to add per-channel completed-block counters blk_cnt0/blk_cnt1.
module tea_arbiter #(
  parameter int NCH   = 2,
  parameter int KEY_W = 128,
  parameter int BLK_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key0,
  input  logic [KEY_W-1:0] key1,
  input  logic [BLK_W-1:0] s0_axis_tdata,
  input  logic             s0_axis_tvalid,
  output logic             s0_axis_tready,
  input  logic [BLK_W-1:0] s1_axis_tdata,
  input  logic             s1_axis_tvalid,
  output logic             s1_axis_tready,
  output logic [BLK_W-1:0] m0_axis_tdata,
  output logic             m0_axis_tvalid,
  input  logic             m0_axis_tready,
  output logic [BLK_W-1:0] m1_axis_tdata,
  output logic             m1_axis_tvalid,
  input  logic             m1_axis_tready,
  output logic [KEY_W-1:0] core_key,
  output logic [BLK_W-1:0] core_s_tdata,
  output logic             core_s_tvalid,
  input  logic             core_s_tready,
  input  logic [BLK_W-1:0] core_m_tdata,
  input  logic             core_m_tvalid,
  output logic             core_m_tready
`ifdef TEA_ARB_STATS_EN
  ,
  output logic [31:0]      blk_cnt0,
  output logic [31:0]      blk_cnt1
`endif
);

  generate
    if (NCH != 2) begin : g_nch_chk
      $error("tea_arbiter: only NCH=2 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

  state_t                    state, state_nxt;
  logic                      last_grant, gnt_q, gnt, acc, dlv_hs;
  logic [BLK_W-1:0]          blk_q, res_q;
  logic [KEY_W-1:0]          key_q;
  logic [NCH-1:0]            s_vld, s_gnt, s_rdy, m_vld, m_rdy;
  logic [NCH-1:0][BLK_W-1:0] s_dat, m_dat;
  logic [NCH-1:0][KEY_W-1:0] key_in;

  assign s_vld  = {s1_axis_tvalid, s0_axis_tvalid};
  assign s_dat  = {s1_axis_tdata, s0_axis_tdata};
  assign key_in = {key1, key0};
  assign m_rdy  = {m1_axis_tready, m0_axis_tready};

  // Tie goes to the channel that was not served last.
  assign gnt    = (&s_vld) ? ~last_grant : s_vld[1];
  assign acc    = (state == IDLE) && (|s_vld);
  assign dlv_hs = (state == DELIVER) && m_rdy[gnt_q];

  always_comb begin
    state_nxt     = state;
    s_gnt         = '0;
    m_vld         = '0;
    core_s_tvalid = 1'b0;
    core_m_tready = 1'b0;
    case (state)
      IDLE: if (|s_vld) begin
        s_gnt[gnt] = 1'b1;
        state_nxt  = ISSUE;
      end
      ISSUE: begin
        core_s_tvalid = 1'b1;
        if (core_s_tready) state_nxt = WAIT;
      end
      WAIT: begin
        core_m_tready = 1'b1;
        if (core_m_tvalid) state_nxt = DELIVER;
      end
      DELIVER: begin
        m_vld[gnt_q] = 1'b1;
        if (m_rdy[gnt_q]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is held low while reset is asserted even though IDLE decodes it.
  assign s_rdy = s_gnt & {NCH{rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      blk_q      <= '0;
      key_q      <= '0;
      res_q      <= '0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        blk_q <= s_dat[gnt];
        key_q <= key_in[gnt];
        gnt_q <= gnt;
      end
      if (state == WAIT && core_m_tvalid) res_q <= core_m_tdata;
      if (dlv_hs) last_grant <= gnt_q;
    end
  end

  // key_q only moves at acceptance, so the core sees a fixed key for every round.
  assign core_key     = key_q;
  assign core_s_tdata = (state == ISSUE) ? blk_q : '0;

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign m_dat[c] = m_vld[c] ? res_q : '0;
    end
  endgenerate

  assign s0_axis_tready = s_rdy[0];
  assign s1_axis_tready = s_rdy[1];
  assign m0_axis_tvalid = m_vld[0];
  assign m1_axis_tvalid = m_vld[1];
  assign m0_axis_tdata  = m_dat[0];
  assign m1_axis_tdata  = m_dat[1];

`ifdef TEA_ARB_STATS_EN
  logic [31:0] blk_cnt0_q, blk_cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt0_q <= '0;
      blk_cnt1_q <= '0;
    end else if (dlv_hs) begin
      if (gnt_q) blk_cnt1_q <= blk_cnt1_q + 32'd1;
      else       blk_cnt0_q <= blk_cnt0_q + 32'd1;
    end
  end

  assign blk_cnt0 = blk_cnt0_q;
  assign blk_cnt1 = blk_cnt1_q;
`endif

endmodule

// File: tb/tb_tea_arbiter.sv
// Bench for tea_arbiter: an iterative TEA core model, a scoreboard monitor and directed/random scenarios.
module tb_tea_arbiter;
  logic          clk = 1'b0;
  logic          rst_n;
  logic [127:0]  key0, key1, core_key;
  logic [63:0]   s0_axis_tdata, s1_axis_tdata, m0_axis_tdata, m1_axis_tdata;
  logic          s0_axis_tvalid, s1_axis_tvalid, s0_axis_tready, s1_axis_tready;
  logic          m0_axis_tvalid, m1_axis_tvalid, m0_axis_tready, m1_axis_tready;
  logic [63:0]   core_s_tdata, core_m_tdata;
  logic          core_s_tvalid, core_s_tready, core_m_tvalid, core_m_tready;
`ifdef TEA_ARB_STATS_EN
  logic [31:0]   blk_cnt0, blk_cnt1;
`endif

  int nvec = 0;
  int nerr = 0;
  int mon_out = 0;

  always #5 clk = ~clk;

  tea_arbiter dut (
    .clk(clk), .rst_n(rst_n), .key0(key0), .key1(key1),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
    .m0_axis_tdata(m0_axis_tdata), .m0_axis_tvalid(m0_axis_tvalid), .m0_axis_tready(m0_axis_tready),
    .m1_axis_tdata(m1_axis_tdata), .m1_axis_tvalid(m1_axis_tvalid), .m1_axis_tready(m1_axis_tready),
`ifdef TEA_ARB_STATS_EN
    .blk_cnt0(blk_cnt0), .blk_cnt1(blk_cnt1),
`endif
    .core_key(core_key), .core_s_tdata(core_s_tdata), .core_s_tvalid(core_s_tvalid),
    .core_s_tready(core_s_tready), .core_m_tdata(core_m_tdata), .core_m_tvalid(core_m_tvalid),
    .core_m_tready(core_m_tready)
  );

  function automatic logic [63:0] tea_enc(input logic [63:0] b, input logic [127:0] k);
    logic [31:0] y, z, sum;
    y = b[63:32]; z = b[31:0]; sum = 32'h0;
    for (int i = 0; i < 32; i++) begin
      sum = sum + 32'h9E3779B9;
      y = y + (((z << 4) + k[127:96]) ^ (z + sum) ^ ((z >> 5) + k[95:64]));
      z = z + (((y << 4) + k[63:32]) ^ (y + sum) ^ ((y >> 5) + k[31:0]));
    end
    return {y, z};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);
  endtask

  // Iterative core: one round per cycle, re-reading core_key on every round.
  task automatic core_model();
    int cst = 0, rnd = 0;
    logic [31:0] y = 0, z = 0, sum = 0;
    logic [127:0] k;
    forever begin
      @(negedge clk);
      if (!rst_n) cst = 0;
      else case (cst)
        0: if (core_s_tvalid && core_s_tready) begin
             y = core_s_tdata[63:32]; z = core_s_tdata[31:0]; sum = 0; rnd = 0; cst = 1;
           end
        1: begin
             k = core_key;
             sum = sum + 32'h9E3779B9;
             y = y + (((z << 4) + k[127:96]) ^ (z + sum) ^ ((z >> 5) + k[95:64]));
             z = z + (((y << 4) + k[63:32]) ^ (y + sum) ^ ((y >> 5) + k[31:0]));
             rnd++;
             if (rnd == 32) cst = 2;
           end
        default: if (core_m_tvalid && core_m_tready) cst = 0;
      endcase
      @(posedge clk); #1;
      core_s_tready = (cst == 0) && ($urandom_range(0, 3) != 0);
      core_m_tvalid = (cst == 2);
      core_m_tdata  = (cst == 2) ? {y, z} : 64'h0;
    end
  endtask

  // Scoreboard: one block outstanding at a time, round-robin by last served channel.
  task automatic monitor();
    logic [63:0] eq[$];
    int cq[$];
    bit busy = 0, deliv = 0, pshs = 0, last = 1;
    logic [63:0] pd = 0, ed;
    logic [127:0] pk = 0;
    logic er0, er1, em0, em1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        eq.delete(); cq.delete(); busy = 0; deliv = 0; pshs = 0; last = 1;
      end else begin
        er0 = !busy && s0_axis_tvalid && (!s1_axis_tvalid || last);
        er1 = !busy && s1_axis_tvalid && (!s0_axis_tvalid || !last);
        nvec++;
        if ({s0_axis_tready, s1_axis_tready} !== {er0, er1}) begin
          nerr++; $display("FAIL grant t=%0t: tready01=%b%b expected %b%b", $time, s0_axis_tready, s1_axis_tready, er0, er1);
        end
        if (pshs) begin
          nvec++;
          if (core_s_tvalid !== 1'b1 || core_s_tdata !== pd || core_key !== pk) begin
            nerr++; $display("FAIL issue t=%0t: vld=%b data=%h key=%h expected 1 %h %h", $time, core_s_tvalid, core_s_tdata, core_key, pd, pk);
          end
        end
        em0 = deliv && cq.size() > 0 && cq[0] == 0;
        em1 = deliv && cq.size() > 0 && cq[0] == 1;
        ed  = (cq.size() > 0) ? eq[0] : 64'h0;
        nvec++;
        if ({m0_axis_tvalid, m1_axis_tvalid} !== {em0, em1}) begin
          nerr++; $display("FAIL m_valid t=%0t: m01=%b%b expected %b%b", $time, m0_axis_tvalid, m1_axis_tvalid, em0, em1);
        end
        nvec++;
        if (m0_axis_tdata !== (em0 ? ed : 64'h0)) begin
          nerr++; $display("FAIL m0_data t=%0t: %h expected %h", $time, m0_axis_tdata, em0 ? ed : 64'h0);
        end
        nvec++;
        if (m1_axis_tdata !== (em1 ? ed : 64'h0)) begin
          nerr++; $display("FAIL m1_data t=%0t: %h expected %h", $time, m1_axis_tdata, em1 ? ed : 64'h0);
        end
        pshs = 0;
        if (((m0_axis_tvalid && m0_axis_tready) || (m1_axis_tvalid && m1_axis_tready)) && cq.size() > 0) begin
          last = (cq[0] == 1);
          void'(eq.pop_front()); void'(cq.pop_front());
          busy = 0; deliv = 0;
        end
        if (core_m_tvalid && core_m_tready) deliv = 1;
        if ((s0_axis_tvalid && s0_axis_tready) || (s1_axis_tvalid && s1_axis_tready)) begin
          if (s1_axis_tvalid && s1_axis_tready) begin pd = s1_axis_tdata; pk = key1; cq.push_back(1); end
          else begin pd = s0_axis_tdata; pk = key0; cq.push_back(0); end
          eq.push_back(tea_enc(pd, pk));
          busy = 1; pshs = 1;
        end
      end
      mon_out = cq.size();
    end
  endtask

  task automatic push_req(input int ch, input logic [63:0] d, input logic [127:0] k, output bit ok);
    ok = 0;
    if (ch == 0) begin s0_axis_tdata = d; key0 = k; s0_axis_tvalid = 1; end
    else         begin s1_axis_tdata = d; key1 = k; s1_axis_tvalid = 1; end
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (ch == 0 ? (s0_axis_tvalid && s0_axis_tready) : (s1_axis_tvalid && s1_axis_tready)) ok = 1;
    end
    @(posedge clk); #1;
    if (ch == 0) s0_axis_tvalid = 0; else s1_axis_tvalid = 0;
  endtask

  task automatic wait_m(input int ch, output logic [63:0] d, output bit ok, output bit other_seen);
    ok = 0; other_seen = 0; d = 64'h0;
    if (ch == 0) m0_axis_tready = 1; else m1_axis_tready = 1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (ch == 0 ? m1_axis_tvalid : m0_axis_tvalid) other_seen = 1;
      if (ch == 0 ? m0_axis_tvalid : m1_axis_tvalid) begin
        d = (ch == 0) ? m0_axis_tdata : m1_axis_tdata; ok = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; s0_axis_tvalid = 1; s1_axis_tvalid = 1;
    s0_axis_tdata = rnd64(); s1_axis_tdata = rnd64(); key0 = rnd128(); key1 = rnd128();
    tick(2);
    nvec++;
    if ({s0_axis_tready, s1_axis_tready, m0_axis_tvalid, m1_axis_tvalid, core_s_tvalid, core_m_tready} !== 6'b0) begin
      nerr++; $display("FAIL reset_ctl: %b expected 000000", {s0_axis_tready, s1_axis_tready, m0_axis_tvalid, m1_axis_tvalid, core_s_tvalid, core_m_tready});
    end
    nvec++;
    if ({m0_axis_tdata, m1_axis_tdata, core_s_tdata} !== 192'h0) begin
      nerr++; $display("FAIL reset_data: m0=%h m1=%h core_s=%h expected 0", m0_axis_tdata, m1_axis_tdata, core_s_tdata);
    end
    nvec++;
    if (core_key !== 128'h0) begin nerr++; $display("FAIL reset_key: %h expected 0", core_key); end
    s0_axis_tvalid = 0; s1_axis_tvalid = 0; rst_n = 1;
    tick(1);
    s1_axis_tvalid = 1; #1;
    nvec++;
    if ({s0_axis_tready, s1_axis_tready} !== 2'b01) begin
      nerr++; $display("FAIL idle_s1_only: tready01=%b%b expected 01", s0_axis_tready, s1_axis_tready);
    end
    s0_axis_tvalid = 1; #1;
    nvec++;
    if ({s0_axis_tready, s1_axis_tready} !== 2'b10) begin
      nerr++; $display("FAIL first_tie: tready01=%b%b expected 10", s0_axis_tready, s1_axis_tready);
    end
    s0_axis_tvalid = 0; s1_axis_tvalid = 0;
    tick(2);
  endtask

  task automatic test_single();
    bit ok, seen1 = 0, done = 0;
    logic [63:0] got = 0;
    push_req(0, 64'h0, 128'h0, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL single_accept: not accepted within bound"); end
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (core_s_tvalid) begin
        nvec++;
        if (core_key !== 128'h0) begin nerr++; $display("FAIL single_key: %h expected 0", core_key); end
      end
      if (m1_axis_tvalid) seen1 = 1;
      if (m0_axis_tvalid) begin got = m0_axis_tdata; done = 1; end
    end
    nvec++;
    if (got !== 64'h41EA3A0A94BAA940) begin nerr++; $display("FAIL single_ct: %h expected 41ea3a0a94baa940", got); end
    nvec++;
    if (seen1) begin nerr++; $display("FAIL single_m1: m1 tvalid=1 expected never"); end
    tick(2);
  endtask

  task automatic test_alternation();
    int order[4];
    int n = 0;
    bit a0, a1;
    do_reset();
    s0_axis_tdata = rnd64(); key0 = rnd128(); s1_axis_tdata = rnd64(); key1 = rnd128();
    s0_axis_tvalid = 1; s1_axis_tvalid = 1;
    for (int c = 0; c < 800 && n < 4; c++) begin
      @(negedge clk);
      a0 = s0_axis_tvalid && s0_axis_tready;
      a1 = s1_axis_tvalid && s1_axis_tready;
      if (a0) begin order[n] = 0; n++; end
      else if (a1) begin order[n] = 1; n++; end
      @(posedge clk); #1;
      if (a0) begin s0_axis_tdata = rnd64(); key0 = rnd128(); end
      if (a1) begin s1_axis_tdata = rnd64(); key1 = rnd128(); end
    end
    s0_axis_tvalid = 0; s1_axis_tvalid = 0;
    nvec++; if (n != 4) begin nerr++; $display("FAIL alt_count: %0d blocks accepted expected 4", n); end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (i < n && order[i] != (i % 2)) begin nerr++; $display("FAIL alt_order[%0d]: ch%0d expected ch%0d", i, order[i], i % 2); end
    end
    tick(100);
  endtask

  task automatic test_key_hold();
    bit ok, done = 0;
    int nwait = 0;
    logic [63:0] d, got = 0;
    logic [127:0] k;
    d = rnd64(); k = rnd128();
    push_req(0, d, k, ok);
    key0 = ~k;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (core_m_tready) begin
        nwait++; nvec++;
        if (core_key !== k) begin nerr++; $display("FAIL key_hold: core_key=%h expected %h", core_key, k); end
      end
      if (m0_axis_tvalid) begin got = m0_axis_tdata; done = 1; end
    end
    nvec++; if (!ok || nwait == 0) begin nerr++; $display("FAIL key_wait: accepted=%b wait_cycles=%0d expected 1 and >0", ok, nwait); end
    nvec++; if (got !== tea_enc(d, k)) begin nerr++; $display("FAIL key_ct: %h expected %h", got, tea_enc(d, k)); end
    tick(2);
  endtask

  task automatic test_backpressure();
    bit ok, up = 0;
    logic [63:0] v = 0;
    m0_axis_tready = 0;
    push_req(0, rnd64(), rnd128(), ok);
    for (int i = 0; i < 300 && !up; i++) begin
      @(negedge clk);
      if (m0_axis_tvalid) begin up = 1; v = m0_axis_tdata; end
    end
    nvec++; if (!up) begin nerr++; $display("FAIL bp_deliver: m0 tvalid=0 expected 1 within bound"); end
    @(posedge clk); #1;
    s0_axis_tdata = rnd64(); s1_axis_tdata = rnd64(); s0_axis_tvalid = 1; s1_axis_tvalid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      nvec++;
      if (m0_axis_tvalid !== 1'b1 || m0_axis_tdata !== v || s0_axis_tready !== 1'b0 || s1_axis_tready !== 1'b0) begin
        nerr++; $display("FAIL bp_hold[%0d]: vld=%b data=%h rdy01=%b%b expected 1 %h 00", i, m0_axis_tvalid, m0_axis_tdata, s0_axis_tready, s1_axis_tready, v);
      end
    end
    @(posedge clk); #1;
    m0_axis_tready = 1; s1_axis_tvalid = 0;
    @(negedge clk);
    @(negedge clk);
    nvec++;
    if ({m0_axis_tvalid, s0_axis_tready, s1_axis_tready} !== 3'b010) begin
      nerr++; $display("FAIL bp_release: m0vld,rdy01=%b expected 010", {m0_axis_tvalid, s0_axis_tready, s1_axis_tready});
    end
    @(posedge clk); #1;
    s0_axis_tvalid = 0;
    tick(100);
  endtask

  task automatic test_reset_wait();
    bit ok, okm, seen0, inwait = 0;
    logic [63:0] d, got;
    logic [127:0] k;
    push_req(0, rnd64(), rnd128(), ok);
    for (int i = 0; i < 50 && !inwait; i++) begin @(negedge clk); inwait = core_m_tready; end
    nvec++; if (!inwait) begin nerr++; $display("FAIL rstw_wait: core_m_tready=0 expected 1 within bound"); end
    s0_axis_tvalid = 1;
    @(posedge clk); #2;
    rst_n = 0; #1;
    nvec++;
    if ({s0_axis_tready, s1_axis_tready, m0_axis_tvalid, m1_axis_tvalid, core_s_tvalid, core_m_tready} !== 6'b0 ||
        {m0_axis_tdata, m1_axis_tdata, core_s_tdata, core_key} !== 320'h0) begin
      nerr++; $display("FAIL rstw_outputs: ctl=%b key=%h expected all 0", {s0_axis_tready, s1_axis_tready, m0_axis_tvalid, m1_axis_tvalid, core_s_tvalid, core_m_tready}, core_key);
    end
    tick(2);
    s0_axis_tvalid = 0; rst_n = 1;
    tick(1);
    d = rnd64(); k = rnd128();
    push_req(1, d, k, ok);
    wait_m(1, got, okm, seen0);
    nvec++; if (!ok || !okm) begin nerr++; $display("FAIL rstw_s1: accepted=%b delivered=%b expected 11", ok, okm); end
    nvec++; if (got !== tea_enc(d, k)) begin nerr++; $display("FAIL rstw_ct: %h expected %h", got, tea_enc(d, k)); end
    nvec++; if (seen0) begin nerr++; $display("FAIL rstw_m0: m0 tvalid=1 expected never"); end
    tick(2);
  endtask

  task automatic test_random(input int ncyc);
    bit a0, a1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      a0 = s0_axis_tvalid && s0_axis_tready;
      a1 = s1_axis_tvalid && s1_axis_tready;
      @(posedge clk); #1;
      if (a0) key0 = rnd128();
      if (a1) key1 = rnd128();
      if (a0 || !s0_axis_tvalid) begin
        s0_axis_tvalid = ($urandom_range(0, 2) == 0);
        if (s0_axis_tvalid) begin s0_axis_tdata = rnd64(); key0 = rnd128(); end
      end
      if (a1 || !s1_axis_tvalid) begin
        s1_axis_tvalid = ($urandom_range(0, 2) == 0);
        if (s1_axis_tvalid) begin s1_axis_tdata = rnd64(); key1 = rnd128(); end
      end
      m0_axis_tready = ($urandom_range(0, 3) != 0);
      m1_axis_tready = ($urandom_range(0, 3) != 0);
    end
    s0_axis_tvalid = 0; s1_axis_tvalid = 0; m0_axis_tready = 1; m1_axis_tready = 1;
    tick(120);
  endtask

`ifdef TEA_ARB_STATS_EN
  task automatic test_stats();
    bit ok, okm, seen;
    int bad = 0;
    logic [63:0] got;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push_req((i < 3) ? 0 : 1, rnd64(), rnd128(), ok);
      wait_m((i < 3) ? 0 : 1, got, okm, seen);
      if (!ok || !okm) bad++;
    end
    nvec++; if (bad != 0) begin nerr++; $display("FAIL stats_xfer: %0d blocks lost expected 0", bad); end
    nvec++; if (blk_cnt0 !== 32'd3) begin nerr++; $display("FAIL stats_cnt0: %0d expected 3", blk_cnt0); end
    nvec++; if (blk_cnt1 !== 32'd2) begin nerr++; $display("FAIL stats_cnt1: %0d expected 2", blk_cnt1); end
    force dut.blk_cnt0_q = 32'hFFFFFFFF;
    tick(1);
    release dut.blk_cnt0_q;
    push_req(0, rnd64(), rnd128(), ok);
    wait_m(0, got, okm, seen);
    nvec++; if (blk_cnt0 !== 32'd0) begin nerr++; $display("FAIL stats_wrap: %h expected 0", blk_cnt0); end
    nvec++; if (blk_cnt1 !== 32'd2) begin nerr++; $display("FAIL stats_cnt1_hold: %0d expected 2", blk_cnt1); end
  endtask
`endif

  initial begin
    rst_n = 0; key0 = 0; key1 = 0;
    s0_axis_tdata = 0; s1_axis_tdata = 0; s0_axis_tvalid = 0; s1_axis_tvalid = 0;
    m0_axis_tready = 1; m1_axis_tready = 1;
    core_s_tready = 0; core_m_tvalid = 0; core_m_tdata = 0;
    fork
      monitor();
      core_model();
    join_none
    tick(3);
    test_reset();
    test_single();
    test_alternation();
    test_key_hold();
    test_backpressure();
    test_reset_wait();
    test_random(1500);
`ifdef TEA_ARB_STATS_EN
    test_stats();
`endif
    nvec++;
    if (mon_out != 0) begin nerr++; $display("FAIL drain: %0d blocks outstanding expected 0", mon_out); end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
